// File: rtl/ram_loader_if.sv
// Byte-stream and RAM write-port bundle for the boot loader.
// The slave modport is the loader's view; master is the host/source side.
interface ram_loader_if #(
    parameter int ADDR_W = 12
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_address;
    logic [31:0]       ram_wdata;
    logic              busy;
    logic              done;
    logic              error;

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, ram_wen, ram_address, ram_wdata, busy, done, error
    );

    modport master (
        output start, in_valid, in_data,
        input  in_ready, ram_wen, ram_address, ram_wdata, busy, done, error
    );
endinterface

// File: rtl/ram_loader.sv
// Boot-time RAM loader: unpacks a length-prefixed, checksummed byte frame
// into little-endian 32-bit words written sequentially from address 0.
module ram_loader #(
    parameter int ADDR_W = 12
) (
    input  logic         clk,
    input  logic         rst,
    ram_loader_if.slave  bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LEN0  = 3'd1;
    localparam logic [2:0] LEN1  = 3'd2;
    localparam logic [2:0] DATA  = 3'd3;
    localparam logic [2:0] WRITE = 3'd4;
    localparam logic [2:0] CSUM  = 3'd5;
    localparam logic [2:0] ERROR = 3'd6;

    localparam int          IDX_W     = ADDR_W - 1;
    localparam logic [31:0] MAX_WORDS = 32'd1 << (ADDR_W - 2);

    logic [2:0]        state;
    logic [7:0]        len_lo;
    logic [7:0]        sum;
    logic [IDX_W-1:0]  word_count;
    logic [IDX_W-1:0]  word_idx;
    logic [1:0]        lane;
    logic [ADDR_W-1:0] ram_address;
    logic [31:0]       ram_wdata;
    logic              done_q;
    logic              error_q;

    logic              xfer;
    logic [15:0]       len_full;
    logic              too_long;
    logic [IDX_W-1:0]  idx_next;

    // Handshake and status are pure decodes of the registered state, so they
    // are glitch-free and already at their reset values while state is IDLE.
    assign bus.in_ready = (state == LEN0) || (state == LEN1) ||
                          (state == DATA) || (state == CSUM);
    assign bus.busy     = (state != IDLE) && (state != ERROR);
    assign bus.ram_wen  = (state == WRITE);

    assign bus.ram_address = ram_address;
    assign bus.ram_wdata   = ram_wdata;
    assign bus.done        = done_q;
    assign bus.error       = error_q;

    assign xfer     = bus.in_valid && bus.in_ready;
    assign len_full = {bus.in_data, len_lo};
    assign too_long = 32'(len_full) > MAX_WORDS;
    assign idx_next = word_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all of them update from the
        // same pre-edge values; a blocking = would leak new values downstream.
        if (rst) begin
            state       <= IDLE;
            len_lo      <= '0;
            sum         <= '0;
            word_count  <= '0;
            word_idx    <= '0;
            lane        <= '0;
            ram_address <= '0;
            ram_wdata   <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= LEN0;
                        error_q  <= 1'b0;
                        word_idx <= '0;
                        lane     <= '0;
                        sum      <= '0;
                    end
                end
                LEN0: begin
                    if (xfer) begin
                        len_lo <= bus.in_data;
                        state  <= LEN1;
                    end
                end
                LEN1: begin
                    if (xfer) begin
                        // Only kept when in range, so the truncation is lossless.
                        word_count <= IDX_W'(len_full);
                        if (too_long) begin
                            state   <= ERROR;
                            error_q <= 1'b1;
                        end else if (len_full == 16'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        ram_wdata[{lane, 3'b000} +: 8] <= bus.in_data;
                        sum  <= sum + bus.in_data;
                        lane <= lane + 2'd1;
                        if (lane == 2'd3) begin
                            state       <= WRITE;
                            ram_address <= ADDR_W'({word_idx, 2'b00});
                        end
                    end
                end
                WRITE: begin
                    word_idx <= idx_next;
                    state    <= (idx_next == word_count) ? CSUM : DATA;
                end
                CSUM: begin
                    if (xfer) begin
                        if (bus.in_data == sum) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
                ERROR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: expected RAM writes are queued as each
// frame is staged and retired by a monitor on every ram_wen pulse.
module tb_ram_loader;
    localparam int ADDR_W = 12;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ram_loader_if #(.ADDR_W(ADDR_W)) bus ();

    ram_loader #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    wr_t        sb[$];
    logic [7:0] frame_q[$];
    int         waits_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Write monitor: every ram_wen pulse must retire the oldest expected write.
    always @(negedge clk) begin
        if (bus.ram_wen === 1'b1) begin
            check("wr_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                wr_t w;
                w = sb.pop_front();
                check("wr_addr", 32'(bus.ram_address), 32'(w.addr));
                check("wr_data", bus.ram_wdata, w.data);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output int waits);
        logic acc;
        bus.in_valid = 1'b0;
        repeat (gap) cycle();
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        waits = 0;
        acc   = 1'b0;
        while (!acc && waits < 64) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) acc = 1'b1;
            else waits++;
            cycle();
        end
        check("byte_accepted", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    // Sends frame_q[from..to-1]; per-byte stall counts land in waits_q.
    task automatic send_range(input int from, input int to, input int max_gap);
        int w;
        for (int i = from; i < to; i++) begin
            send_byte(frame_q[i], $urandom_range(0, max_gap), w);
            waits_q.push_back(w);
        end
    endtask

    task automatic push_basic();
        sb.push_back('{addr: 12'h000, data: 32'h1234_5678});
        sb.push_back('{addr: 12'h004, data: 32'hDEAD_BEEF});
    endtask

    task automatic set_basic(input logic [7:0] csum);
        frame_q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                    8'hEF, 8'hBE, 8'hAD, 8'hDE, csum};
    endtask

    task automatic expect_done(input string tag);
        @(negedge clk);
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_error"}, 32'(bus.error), 32'd0);
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        cycle();
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset values
        repeat (2) cycle();
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_ram_wen", 32'(bus.ram_wen), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        check("rst_addr", 32'(bus.ram_address), 32'd0);
        check("rst_wdata", bus.ram_wdata, 32'd0);
        cycle();
        rst = 1'b0;
        cycle();

        // Basic load
        push_basic();
        set_basic(8'h4C);
        do_start();
        @(negedge clk);
        check("start_busy", 32'(bus.busy), 32'd1);
        check("start_in_ready", 32'(bus.in_ready), 32'd1);
        cycle();
        send_range(0, 11, 0);
        expect_done("basic");

        // Bad checksum: both words still land, error held, no done
        push_basic();
        set_basic(8'h4D);
        do_start();
        send_range(0, 11, 0);
        @(negedge clk);
        check("badsum_error", 32'(bus.error), 32'd1);
        check("badsum_busy", 32'(bus.busy), 32'd0);
        check("badsum_done", 32'(bus.done), 32'd0);
        check("badsum_in_ready", 32'(bus.in_ready), 32'd0);
        check("badsum_sb_empty", 32'(sb.size()), 32'd0);
        repeat (4) cycle();
        @(negedge clk);
        check("badsum_error_held", 32'(bus.error), 32'd1);
        cycle();
        do_start();
        @(negedge clk);
        check("restart_error_clr", 32'(bus.error), 32'd0);
        check("restart_busy", 32'(bus.busy), 32'd1);
        cycle();

        // Empty frame, good then bad checksum
        frame_q = '{8'h00, 8'h00, 8'h00};
        send_range(0, 3, 0);
        expect_done("empty");
        frame_q = '{8'h00, 8'h00, 8'h01};
        do_start();
        send_range(0, 3, 0);
        @(negedge clk);
        check("empty_bad_error", 32'(bus.error), 32'd1);
        check("empty_bad_done", 32'(bus.done), 32'd0);
        cycle();

        // Overflow: N = 1025 exceeds 1024 words
        frame_q = '{8'h01, 8'h04};
        do_start();
        send_range(0, 2, 0);
        @(negedge clk);
        check("ovf_error", 32'(bus.error), 32'd1);
        check("ovf_in_ready", 32'(bus.in_ready), 32'd0);
        check("ovf_busy", 32'(bus.busy), 32'd0);
        cycle();
        @(negedge clk);
        check("ovf_idle_busy", 32'(bus.busy), 32'd0);
        check("ovf_error_level", 32'(bus.error), 32'd1);
        cycle();

        // Exactly capacity (N = 1024) is accepted; abandon it via reset
        frame_q = '{8'h00, 8'h04};
        do_start();
        send_range(0, 2, 0);
        @(negedge clk);
        check("cap_error", 32'(bus.error), 32'd0);
        check("cap_busy", 32'(bus.busy), 32'd1);
        check("cap_in_ready", 32'(bus.in_ready), 32'd1);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();

        // Random gaps with a start pulse ignored mid-load
        push_basic();
        set_basic(8'h4C);
        do_start();
        send_range(0, 4, 3);
        do_start();
        send_range(4, 11, 3);
        expect_done("gaps");

        // Valid held high: a one-cycle stall follows each 4th data byte
        push_basic();
        set_basic(8'h4C);
        waits_q.delete();
        do_start();
        send_range(0, 11, 0);
        for (int i = 0; i < 11; i++)
            check($sformatf("stall_%0d", i), 32'(waits_q[i]),
                  (i == 6 || i == 10) ? 32'd1 : 32'd0);
        expect_done("hold");

        // Reset after 5 data bytes; rst also wins over a concurrent start
        sb.push_back('{addr: 12'h000, data: 32'h1234_5678});
        frame_q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hAA};
        do_start();
        send_range(0, 7, 0);
        rst       = 1'b1;
        bus.start = 1'b1;
        cycle();
        @(negedge clk);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("mid_rst_ram_wen", 32'(bus.ram_wen), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_error", 32'(bus.error), 32'd0);
        check("mid_rst_addr", 32'(bus.ram_address), 32'd0);
        check("mid_rst_wdata", bus.ram_wdata, 32'd0);
        check("mid_rst_sb_empty", 32'(sb.size()), 32'd0);
        cycle();
        rst       = 1'b0;
        bus.start = 1'b0;
        cycle();
        push_basic();
        set_basic(8'h4C);
        do_start();
        send_range(0, 11, 1);
        expect_done("after_rst");

        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_loader.md
# ram_loader

Boot-time initiator for the on-chip word RAM write port. It accepts a framed byte stream over a valid/ready handshake, packs the data bytes little-endian into 32-bit words, and writes them sequentially from byte address 0. It then checks a trailing checksum and reports done or error. It sits between the UART receive path and the RAM write port, and its `busy` output holds the CPU in reset during a load.

## Interface

- `ADDR_W`, default 12: RAM byte-address width. Capacity is 2^(ADDR_W-2) words.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: one-cycle request to begin a load session. Ignored while `busy`=1.
- `in_valid` in 1: byte available on `in_data`.
- `in_data` in 8: stream byte.
- `in_ready` out 1: loader accepts a byte this cycle. A transfer happens when `in_valid && in_ready`.
- `ram_wen` out 1: RAM write enable, one-cycle pulse per word.
- `ram_address` out ADDR_W: byte address, word-aligned. Bits [1:0] are always 0.
- `ram_wdata` out 32: packed word.
- `busy` out 1: session in progress. Used as the CPU reset hold.
- `done` out 1: one-cycle pulse when a load succeeds.
- `error` out 1: level signal. Set on a failed load; cleared by the next accepted `start` or by `rst`.

## Operation

- Frame format:
  - LEN_LO, LEN_HI: 16-bit word count N, little-endian.
  - 4·N data bytes, little-endian within each word.
  - CSUM: must equal the sum of all data bytes mod 256.
- States: IDLE, LEN0, LEN1, DATA, WRITE, CSUM, ERROR.
- IDLE:
  - `start` → LEN0.
  - Clears `error`, word index, byte lane and running sum.
- LEN0: on transfer, latch LEN_LO → LEN1.
- LEN1: on transfer, latch LEN_HI, then:
  - N > 2^(ADDR_W-2) → ERROR.
  - N = 0 → CSUM.
  - Otherwise → DATA.
- DATA: on each transfer, place the byte in lane 0..3 of `ram_wdata`, add it to the running sum, and advance the lane. After the lane-3 byte → WRITE.
- WRITE:
  - `ram_wen`=1 for exactly one cycle, with `ram_address` = word_index·4.
  - `in_ready`=0.
  - Word index then increments. If index = N → CSUM, else → DATA.
- CSUM: on transfer, compare the byte with the running sum.
  - Match → IDLE with a `done` pulse.
  - Mismatch → ERROR.
- ERROR:
  - `error`=1, `busy`=0, `in_ready`=0.
  - Returns to IDLE on the next cycle. `error` stays high until the next `start`.
- `in_ready`=1 exactly in LEN0, LEN1, DATA and CSUM.
- `busy`=1 in every state except IDLE and ERROR.
- Sums use 8-bit wrap-around arithmetic. The word index is ADDR_W-1 bits wide, so the count N itself fits.
- Words already written before an error are not undone. RAM contents after a failed load are undefined to software.
- `rst` in any state aborts the session immediately. The next session restarts at address 0.

## Timing

- Reset values:
  - `in_ready`, `ram_wen`, `busy`, `done`, `error` = 0.
  - `ram_address` = 0, `ram_wdata` = 0.
  - State = IDLE.
- `start` sampled at edge k → `busy`=1 and `in_ready`=1 from cycle k+1.
- Lane-3 data byte accepted at edge k → `ram_wen`=1 during cycle k+1. The RAM captures the word at edge k+2.
- `ram_address` and `ram_wdata` are registered and stable for the whole `ram_wen` cycle.
- A byte offered during the WRITE cycle is not consumed. The source must hold it until `in_ready`.
- Matching CSUM accepted at edge k → `done`=1 and `busy`=0 during cycle k+1.
- Failure (bad CSUM, or LEN_HI when N is too large) accepted at edge k → `error`=1 and `busy`=0 from cycle k+1.
- Minimum session length: 3 + 5·N cycles of transfer/write activity.
- `rst` and `start` in the same cycle: `rst` wins.
- `start` while `busy`: no effect on state or counters.

## Test plan

- Basic load: start, then bytes 02 00 78 56 34 12 EF BE AD DE 4C → exactly two `ram_wen` pulses:
  - 0x12345678 @ 0x000, then 0xDEADBEEF @ 0x004.
  - `done` pulse one cycle after 0x4C; `error`=0; `busy` falls together with `done`.
- Bad checksum: same frame ending with 0x4D → both words are written, `error`=1 and held, no `done`. A following start clears `error`.
- Empty frame: 00 00 00 → no `ram_wen`, `done` pulse. Frame 00 00 01 → `error`=1.
- Overflow, with ADDR_W=12: length 01 04 (N=1025) → `error`=1 one cycle after the second length byte, no `ram_wen`, `in_ready`=0.
- Backpressure and gaps, basic frame:
  - Random `in_valid` gaps produce identical writes and `done`.
  - Holding `in_valid` high shows `in_ready`=0 exactly in the cycle after each 4th data byte, with no byte lost or duplicated.
  - A `start` pulse issued mid-load is ignored.
- Reset mid-load: assert `rst` after 5 data bytes of a 2-word frame → all outputs return to reset values next cycle. A fresh basic load then writes 0x12345678 @ 0x000 and ends with `done`.
